// File: rtl/counter_word_source.sv
// Prescaled 10-bit up/down counter that presents each new count on a
// valid/ack word bus and holds it stable until the consumer accepts it.
//
//   state | meaning
//   IDLE  | counter stopped, waiting for en or load
//   RUN   | prescaler counting toward the next tick
//   HOLD  | word presented, waiting for word_ack; ticks here are dropped
module counter_word_source #(
    parameter int WIDTH = 10,
    parameter int DIV   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             word_ack_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic             word_valid_o,
    output logic             wrap_o,
    output logic             overrun_o
);

    // A divide ratio of 1 still needs a one-bit prescaler so the compare exists.
    localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    ps_q, ps_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] count_step;
    logic             ps_last;
    logic             at_wrap;

    // The presented word always equals the internal count (both change only on
    // load or tick), so a single register serves as both.
    assign word_out_o   = count_q;
    assign word_valid_o = valid_q;
    assign wrap_o       = wrap_q;
    assign overrun_o    = ovr_q;

    assign count_step = dir_i ? (count_q + 1'b1) : (count_q - 1'b1);
    assign ps_last    = (ps_q == PS_LAST);
    assign at_wrap    = dir_i ? (count_q == MAX) : (count_q == '0);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            ps_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ps_q    <= ps_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state and datapath update; wrap defaults low so it pulses one cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ps_d    = ps_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    count_d = load_val_i;
                    valid_d = 1'b1;
                    ps_d    = '0;
                    state_d = HOLD;
                end else if (en_i) begin
                    ps_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load_i) begin
                    count_d = load_val_i;
                    valid_d = 1'b1;
                    ps_d    = '0;
                    state_d = HOLD;
                end else if (!en_i) begin
                    ps_d    = '0;
                    state_d = IDLE;
                end else if (ps_last) begin
                    ps_d    = '0;
                    count_d = count_step;
                    valid_d = 1'b1;
                    wrap_d  = at_wrap;
                    state_d = HOLD;
                end else begin
                    ps_d = ps_q + 1'b1;
                end
            end
            HOLD: begin
                // A tick that matures while the word is unacknowledged is lost.
                if (en_i) begin
                    if (ps_last) begin
                        ovr_d = 1'b1;
                        ps_d  = '0;
                    end else begin
                        ps_d = ps_q + 1'b1;
                    end
                end
                if (word_ack_i) begin
                    valid_d = 1'b0;
                    ps_d    = '0;
                    state_d = en_i ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ps_d    = '0;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_word_source.sv
// Self-checking bench for counter_word_source: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_counter_word_source;

    localparam int WIDTH = 10;
    localparam int DIV   = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0, dir = 1'b0, load = 1'b0, ack = 1'b0;
    logic [WIDTH-1:0] lv = '0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid, wrap, overrun;

    counter_word_source #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .dir_i       (dir),
        .load_i      (load),
        .load_val_i  (lv),
        .word_ack_i  (ack),
        .word_out_o  (word_out),
        .word_valid_o(word_valid),
        .wrap_o      (wrap),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: "running" means the counter is advancing toward a
    // tick, "phase" counts enabled cycles since the last restart.
    int m_word, m_valid, m_wrap, m_ovr, m_run, m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word = 0; m_valid = 0; m_wrap = 0; m_ovr = 0; m_run = 0; m_phase = 0;
    endtask

    task automatic model_edge();
        m_wrap = 0;
        if (m_valid != 0) begin
            if (en) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_ovr   = 1;
                    m_phase = 0;
                end
            end
            if (ack) begin
                m_valid = 0;
                m_phase = 0;
                m_run   = en ? 1 : 0;
            end
        end else if (load) begin
            m_word  = int'(lv);
            m_valid = 1;
            m_phase = 0;
        end else if (m_run == 0) begin
            if (en) begin
                m_run   = 1;
                m_phase = 0;
            end
        end else if (!en) begin
            m_run   = 0;
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_wrap  = dir ? int'(m_word == MAXV) : int'(m_word == 0);
                m_word  = dir ? (m_word + 1) % (MAXV + 1) : (m_word + MAXV) % (MAXV + 1);
                m_valid = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("word_out", 32'(word_out), m_word);
        chk("word_valid", 32'(word_valid), m_valid);
        chk("wrap", 32'(wrap), m_wrap);
        chk("overrun", 32'(overrun), m_ovr);
    endtask

    // Drive one cycle of inputs at the falling edge, let the DUT and model take
    // the rising edge, then compare at the next falling edge.
    task automatic step(input logic e, input logic d, input logic l,
                        input logic [WIDTH-1:0] v, input logic a);
        en = e; dir = d; load = l; lv = v; ack = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_valid(input logic e, input logic d, output int nsteps);
        nsteps = -1;
        for (int i = 1; i <= 20; i++) begin
            step(e, d, 1'b0, '0, 1'b0);
            if (word_valid) begin
                nsteps = i;
                break;
            end
        end
        if (nsteps < 0) chk("wait_valid_timeout", 32'(word_valid), 1);
    endtask

    // Raise reset between clock edges and confirm outputs clear with no edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("async_word_out", 32'(word_out), 0);
        chk("async_word_valid", 32'(word_valid), 0);
        chk("async_wrap", 32'(wrap), 0);
        chk("async_overrun", 32'(overrun), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rises[$];
        int words[$];
        int age;
        int ns;
        logic pv;

        model_reset();
        #1;
        chk("reset_word_out", 32'(word_out), 0);
        chk("reset_word_valid", 32'(word_valid), 0);
        chk("reset_wrap", 32'(wrap), 0);
        chk("reset_overrun", 32'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;

        // Count up, ack in the second cycle of each word: rises every DIV+2.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        age = -1;
        pv  = 1'b0;
        for (int i = 1; i <= 40 && words.size() < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, (age == 1));
            if (word_valid && !pv) begin
                rises.push_back(i);
                words.push_back(int'(word_out));
                age = 0;
            end else if (word_valid) begin
                age++;
            end
            pv = word_valid;
        end
        chk("up_word_count", words.size(), 4);
        for (int k = 0; k < words.size(); k++) begin
            chk("up_word_value", words[k], k + 1);
            if (k == 0) chk("up_first_rise", rises[0], DIV);
            else        chk("up_rise_spacing", rises[k] - rises[k-1], DIV + 2);
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Up wrap from a loaded MAX.
        step(1'b0, 1'b1, 1'b1, 10'(MAXV), 1'b0);
        chk("load_max_word", 32'(word_out), MAXV);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        wait_valid(1'b1, 1'b1, ns);
        chk("up_wrap_word", 32'(word_out), 0);
        chk("up_wrap_flag", 32'(wrap), 1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk("up_wrap_one_cycle", 32'(wrap), 0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Overrun: hold word 1 for 10 cycles, load ignored meanwhile.
        step(1'b0, 1'b1, 1'b1, 10'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        wait_valid(1'b1, 1'b1, ns);
        chk("ovr_first_word", 32'(word_out), 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, (i == 5), 10'd77, 1'b0);
            if (i == 3) chk("ovr_set_by_4th", 32'(overrun), 1);
        end
        chk("ovr_word_held", 32'(word_out), 1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        wait_valid(1'b1, 1'b1, ns);
        chk("ovr_next_word", 32'(word_out), 2);
        chk("ovr_sticky", 32'(overrun), 1);

        // Async reset mid-HOLD with word 5 presented.
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 10'd5, 1'b0);
        chk("hold_word5", 32'(word_out), 5);
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // Down wrap from zero.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        wait_valid(1'b1, 1'b0, ns);
        chk("down_wrap_word", 32'(word_out), MAXV);
        chk("down_wrap_flag", 32'(wrap), 1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        wait_valid(1'b1, 1'b0, ns);
        chk("down_next_word", 32'(word_out), MAXV - 1);
        chk("down_next_wrap", 32'(wrap), 0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Enable drop two cycles into RUN, then restart.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("endrop_no_valid", 32'(word_valid), 0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        wait_valid(1'b1, 1'b1, ns);
        chk("endrop_latency", ns, DIV);
        chk("endrop_word", 32'(word_out), MAXV);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [WIDTH-1:0] v;
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = 10'(MAXV);
                default: v = 10'($urandom_range(0, MAXV));
            endcase
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15) == 0, v, $urandom_range(0, 2) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
